// File: rtl/pc_stack_if.sv
// Control and status bundle between the instruction decoder and the program-counter unit.
interface pc_stack_if #(
  parameter int PC_W   = 8,
  parameter int OFFS_W = 8,
  parameter int DEPTH  = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic              en;
  logic              branch;
  logic              call;
  logic              ret;
  logic [OFFS_W-1:0] offset;
  logic              clear_err;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   ret_top;
  logic [DW-1:0]     depth;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output en, branch, call, ret, offset, clear_err,
    input  pc, ret_top, depth, full, empty, overflow, underflow
  );

  modport slave (
    input  en, branch, call, ret, offset, clear_err,
    output pc, ret_top, depth, full, empty, overflow, underflow
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with internal sequential/relative target arithmetic and a hardware return-address stack.
module pc_stack_unit #(
  parameter int          PC_W     = 8,
  parameter int          OFFS_W   = 8,
  parameter int          DEPTH    = 4,
  parameter int          WRAP     = 0,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic       clk,
  input  logic       reset,
  pc_stack_if.slave  bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] stack_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;    // next free slot; oldest entry when full
  logic [DW-1:0]   depth_q, depth_d;
  logic            ovf_q, unf_q;
  logic            push, ovf_set, unf_set;
  logic [PC_W-1:0] seq, rel, top;
  logic            is_full, is_empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
  endfunction

  assign seq      = pc_q + 1'b1;
  // Size cast of a signed operand sign-extends when widening and truncates when narrowing.
  assign rel      = pc_q + PC_W'(signed'(bus.offset));
  assign is_full  = (depth_q == DW'(DEPTH));
  assign is_empty = (depth_q == '0);
  assign top      = stack_q[ptr_dec(ptr_q)];

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_d    = seq;
    depth_d = depth_q;
    ptr_d   = ptr_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!bus.en) begin
      pc_d = pc_q;
    end else if (bus.ret) begin
      if (!is_empty) begin
        pc_d    = top;
        depth_d = depth_q - 1'b1;
        ptr_d   = ptr_dec(ptr_q);
      end else begin
        unf_set = 1'b1;
      end
    end else if (bus.call) begin
      if (!is_full) begin
        push    = 1'b1;
        pc_d    = rel;
        depth_d = depth_q + 1'b1;
        ptr_d   = ptr_inc(ptr_q);
      end else if (WRAP != 0) begin
        push    = 1'b1;
        pc_d    = rel;
        ptr_d   = ptr_inc(ptr_q);
      end else begin
        ovf_set = 1'b1;
      end
    end else if (bus.branch) begin
      pc_d = rel;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      ptr_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_set | (ovf_q & ~bus.clear_err);
      unf_q   <= unf_set | (unf_q & ~bus.clear_err);
    end
  end

  // NOTE: the stack array is reset on purpose so stale return addresses never survive a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else if (push) begin
      stack_q[ptr_q] <= seq;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.ret_top   = is_empty ? '0 : top;
  assign bus.depth     = depth_q;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Drives a saturating and a circular instance with identical stimulus and checks both against a stack model.
module tb_pc_stack_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       d_en, d_br, d_call, d_ret, d_clr;
  logic [7:0] d_off;

  pc_stack_if #(.PC_W(8), .OFFS_W(8), .DEPTH(4)) i0 ();
  pc_stack_if #(.PC_W(8), .OFFS_W(8), .DEPTH(4)) i1 ();

  assign i0.en = d_en;  assign i0.branch = d_br;  assign i0.call = d_call;
  assign i0.ret = d_ret; assign i0.offset = d_off; assign i0.clear_err = d_clr;
  assign i1.en = d_en;  assign i1.branch = d_br;  assign i1.call = d_call;
  assign i1.ret = d_ret; assign i1.offset = d_off; assign i1.clear_err = d_clr;

  pc_stack_unit #(.PC_W(8), .OFFS_W(8), .DEPTH(4), .WRAP(0), .RESET_PC(8'h00))
    dut0 (.clk(clk), .reset(reset), .bus(i0.slave));
  pc_stack_unit #(.PC_W(8), .OFFS_W(8), .DEPTH(4), .WRAP(1), .RESET_PC(8'h00))
    dut1 (.clk(clk), .reset(reset), .bus(i1.slave));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: ms[w][0..mc-1] holds return addresses from oldest to newest.
  logic [7:0] m_pc [2];
  logic [7:0] ms [2][4];
  int         mc [2];
  bit         m_ovf [2];
  bit         m_unf [2];

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_pc[w] = 8'h00; mc[w] = 0; m_ovf[w] = 0; m_unf[w] = 0;
      for (int i = 0; i < 4; i++) ms[w][i] = 8'h00;
    end
  endtask

  task automatic model_step(input int w);
    logic [7:0] seq, rel;
    bit ovf_ev, unf_ev;
    seq = m_pc[w] + 8'd1;
    rel = m_pc[w] + d_off;
    ovf_ev = 0; unf_ev = 0;
    if (d_en) begin
      if (d_ret) begin
        if (mc[w] > 0) begin m_pc[w] = ms[w][mc[w]-1]; mc[w]--; end
        else begin m_pc[w] = seq; unf_ev = 1; end
      end else if (d_call) begin
        if (mc[w] < 4) begin ms[w][mc[w]] = seq; mc[w]++; m_pc[w] = rel; end
        else if (w == 1) begin
          for (int i = 0; i < 3; i++) ms[w][i] = ms[w][i+1];
          ms[w][3] = seq; m_pc[w] = rel;
        end else begin m_pc[w] = seq; ovf_ev = 1; end
      end else if (d_br) m_pc[w] = rel;
      else m_pc[w] = seq;
    end
    m_ovf[w] = ovf_ev | (m_ovf[w] & !d_clr);
    m_unf[w] = unf_ev | (m_unf[w] & !d_clr);
  endtask

  task automatic check_all();
    logic [7:0] top0, top1;
    top0 = (mc[0] > 0) ? ms[0][mc[0]-1] : 8'h00;
    top1 = (mc[1] > 0) ? ms[1][mc[1]-1] : 8'h00;
    check("w0_pc", i0.pc, m_pc[0]);         check("w1_pc", i1.pc, m_pc[1]);
    check("w0_depth", i0.depth, mc[0]);     check("w1_depth", i1.depth, mc[1]);
    check("w0_full", i0.full, mc[0] == 4);  check("w1_full", i1.full, mc[1] == 4);
    check("w0_empty", i0.empty, mc[0] == 0); check("w1_empty", i1.empty, mc[1] == 0);
    check("w0_top", i0.ret_top, top0);      check("w1_top", i1.ret_top, top1);
    check("w0_ovf", i0.overflow, m_ovf[0]); check("w1_ovf", i1.overflow, m_ovf[1]);
    check("w0_unf", i0.underflow, m_unf[0]); check("w1_unf", i1.underflow, m_unf[1]);
  endtask

  task automatic drive(input logic en, br, call, ret, input logic [7:0] off, input logic clr);
    d_en = en; d_br = br; d_call = call; d_ret = ret; d_off = off; d_clr = clr;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  task automatic op(input logic en, br, call, ret, input logic [7:0] off, input logic clr);
    drive(en, br, call, ret, off, clr);
    cycle();
  endtask

  task automatic idle();           op(1, 0, 0, 0, 8'h00, 0); endtask
  task automatic branch_to(input logic [7:0] tgt); op(1, 1, 0, 0, tgt - m_pc[0], 0); endtask
  task automatic do_call(input logic [7:0] off); op(1, 0, 1, 0, off, 0); endtask
  task automatic do_ret();         op(1, 0, 0, 1, 8'h00, 0); endtask

  // Asynchronous reset: outputs must clear before the next clock edge.
  task automatic apply_reset();
    drive(1, 0, 0, 0, 8'h00, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 0, 0, 0, 8'h00, 0);
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Sequential, wrap and stall
    for (int i = 1; i <= 5; i++) begin
      idle();
      check("seq_pc", i0.pc, i);
    end
    branch_to(8'hFF);
    idle();
    check("wrap_pc", i0.pc, 8'h00);
    branch_to(8'h42);
    for (int i = 0; i < 3; i++) op(0, 0, 1, 0, 8'h11, 0);
    check("stall_pc", i0.pc, 8'h42);

    // PC-relative branches
    branch_to(8'h10); op(1, 1, 0, 0, 8'hFC, 0); check("br_back", i0.pc, 8'h0C);
    branch_to(8'h10); op(1, 1, 0, 0, 8'h05, 0); check("br_fwd", i0.pc, 8'h15);
    branch_to(8'h02); op(1, 1, 0, 0, 8'hF0, 0); check("br_wrap", i0.pc, 8'hF2);

    // Call and return
    branch_to(8'h20);
    do_call(8'h10);
    check("call_pc", i0.pc, 8'h30);
    check("call_top", i0.ret_top, 8'h21);
    do_ret();
    check("ret_pc", i0.pc, 8'h21);
    check("ret_empty", i0.empty, 1);

    // Overflow in both policies
    apply_reset();
    for (int i = 0; i < 4; i++) do_call(8'h08);
    check("ovf_full", i0.full, 1);
    branch_to(8'h50);
    do_call(8'h10);
    check("ovf_pc0", i0.pc, 8'h51);
    check("ovf_flag0", i0.overflow, 1);
    check("ovf_depth0", i0.depth, 4);
    check("wrap_pc1", i1.pc, 8'h60);
    check("wrap_flag1", i1.overflow, 0);
    do_ret();
    check("wrap_ret1", i1.pc, 8'h51);
    for (int i = 0; i < 3; i++) do_ret();
    do_ret();
    check("wrap_unf1", i1.underflow, 1);

    // Underflow, clear and priority
    apply_reset();
    branch_to(8'h08);
    do_ret();
    check("unf_pc", i0.pc, 8'h09);
    check("unf_flag", i0.underflow, 1);
    op(1, 0, 0, 0, 8'h00, 1);
    check("unf_clear", i0.underflow, 0);
    do_call(8'h04);
    op(1, 0, 1, 1, 8'h04, 0);
    check("prio_depth", i0.depth, 0);
    op(1, 0, 0, 1, 8'h00, 1);
    check("set_wins", i0.underflow, 1);

    // Mid-run reset with a live stack
    apply_reset();
    do_call(8'h10);
    do_call(8'h10);
    branch_to(8'h37);
    apply_reset();
    check("rst_pc", i0.pc, 8'h00);
    check("rst_depth", i0.depth, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(9, 0) != 0, $urandom_range(3, 0) == 0,
            $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0,
            8'($urandom), $urandom_range(7, 0) == 0);
      cycle();
      if ($urandom_range(99, 0) == 0) apply_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
